// File: rtl/vector_op_arbiter_if.sv
// Requester and response handshake bundle for vector_op_arbiter.
// master drives operands and rsp_ready; slave (the arbiter) drives readies and results.
interface vector_op_arbiter_if #(
   parameter int WIDTH = 3
);
   logic               req0_valid;
   logic               req0_ready;
   logic [WIDTH-1:0]   req0_a;
   logic [WIDTH-1:0]   req0_b;
   logic               req1_valid;
   logic               req1_ready;
   logic [WIDTH-1:0]   req1_a;
   logic [WIDTH-1:0]   req1_b;
   logic               rsp_valid;
   logic               rsp_ready;
   logic               rsp_id;
   logic [WIDTH-1:0]   rsp_or_bitwise;
   logic               rsp_or_logical;
   logic [2*WIDTH-1:0] rsp_not;

   modport master (
      output req0_valid, req0_a, req0_b,
      output req1_valid, req1_a, req1_b,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_or_bitwise, rsp_or_logical, rsp_not
   );

   modport slave (
      input  req0_valid, req0_a, req0_b,
      input  req1_valid, req1_a, req1_b,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_or_bitwise, rsp_or_logical, rsp_not
   );
endinterface

// File: rtl/vector_op_arbiter.sv
// Two-requester round-robin front end for a registered OR/NOT vector unit; one cycle accept-to-result.
// Readies drop to 0 while the single result buffer is full and not being drained this cycle.
module vector_op_arbiter #(
   parameter int WIDTH = 3,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   vector_op_arbiter_if.slave bus,
   output logic [CNT_W-1:0]   done_count
);
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t             state;
   logic               prio;
   logic               rsp_id_q;
   logic [WIDTH-1:0]   or_bitwise_q;
   logic               or_logical_q;
   logic [2*WIDTH-1:0] not_q;

   logic               can_load;
   logic               drain;
   logic               grant0;
   logic               grant1;
   logic               load;
   logic               win_id;
   logic [WIDTH-1:0]   win_a;
   logic [WIDTH-1:0]   win_b;

   // A full buffer may still accept when the consumer drains it in the same cycle.
   assign drain    = (state == FULL) & bus.rsp_ready;
   assign can_load = (state == EMPTY) | bus.rsp_ready;

   assign grant0 = bus.req0_valid & (~bus.req1_valid | ~prio);
   assign grant1 = bus.req1_valid & (~bus.req0_valid |  prio);

   assign bus.req0_ready = can_load & grant0;
   assign bus.req1_ready = can_load & grant1;

   assign load   = can_load & (grant0 | grant1);
   assign win_id = grant1;
   assign win_a  = grant1 ? bus.req1_a : bus.req0_a;
   assign win_b  = grant1 ? bus.req1_b : bus.req0_b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= EMPTY;
         prio         <= 1'b0;
         rsp_id_q     <= 1'b0;
         or_bitwise_q <= '0;
         or_logical_q <= 1'b0;
         not_q        <= '0;
         done_count   <= '0;
      end else begin
         if (load) begin
            state        <= FULL;
            rsp_id_q     <= win_id;
            or_bitwise_q <= win_a | win_b;
            or_logical_q <= (|win_a) | (|win_b);
            not_q        <= {~win_b, ~win_a};
            prio         <= ~win_id;
         end else if (drain) begin
            state <= EMPTY;
         end
         if (drain) begin
            done_count <= done_count + CNT_W'(1);
         end
      end
   end

   assign bus.rsp_valid      = (state == FULL);
   assign bus.rsp_id         = rsp_id_q;
   assign bus.rsp_or_bitwise = or_bitwise_q;
   assign bus.rsp_or_logical = or_logical_q;
   assign bus.rsp_not        = not_q;
endmodule
